// File: rtl/hypipe_out_sched_pkg.sv
// Shared definitions for the hybrid-pipeline output scheduler: beat tags,
// FSM state encodings and the packet beat width.
package hypipe_out_sched_pkg;

  localparam int PKT_WIDTH = 134;

  localparam logic [1:0] TAG_BODY   = 2'b00;
  localparam logic [1:0] TAG_HEAD   = 2'b01;
  localparam logic [1:0] TAG_TAIL   = 2'b10;
  localparam logic [1:0] TAG_SINGLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BODY = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  // Both head-carrying tags (01 and 11) have bit 0 set.
  function automatic logic isHeadTag(input logic [1:0] tag);
    return tag[0];
  endfunction

endpackage

// File: rtl/hypipe_out_reg.sv
// Single-entry valid/ready output register. o_ld tells the scheduler when a
// new beat may be written into the register.
module hypipe_out_reg
  import hypipe_out_sched_pkg::*;
#(
  parameter int META_WIDTH = 128
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [PKT_WIDTH-1:0]  i_data,
  input  logic                  i_meta_valid,
  input  logic [META_WIDTH-1:0] i_meta,
  input  logic                  i_ready,
  output logic                  o_ld,
  output logic                  o_data_valid,
  output logic [PKT_WIDTH-1:0]  o_data,
  output logic                  o_meta_valid,
  output logic [META_WIDTH-1:0] o_meta
);

  logic                  r_dataValid;
  logic [PKT_WIDTH-1:0]  r_data;
  logic                  r_metaValid;
  logic [META_WIDTH-1:0] r_meta;

  assign o_ld         = !r_dataValid || i_ready;
  assign o_data_valid = r_dataValid;
  assign o_data       = r_data;
  assign o_meta_valid = r_metaValid;
  assign o_meta       = r_meta;

  // o_meta keeps the head's metadata for the whole packet; body beats leave it alone.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dataValid <= 1'b0;
      r_data      <= '0;
      r_metaValid <= 1'b0;
      r_meta      <= '0;
    end else if (i_load) begin
      r_dataValid <= 1'b1;
      r_data      <= i_data;
      r_metaValid <= i_meta_valid;
      if (i_meta_valid) begin
        r_meta <= i_meta;
      end
    end else if (i_ready) begin
      r_dataValid <= 1'b0;
      r_metaValid <= 1'b0;
    end
  end

endmodule

// File: rtl/hypipe_out_sched.sv
// Output scheduler: pairs packet beats with metadata and emits them downstream.
// Define HYPIPE_OUT_STAT_EN to add saturating packet/drop/error counters.
module hypipe_out_sched
  import hypipe_out_sched_pkg::*;
#(
  parameter int META_WIDTH  = 128,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_empty_pkt,
  input  logic [PKT_WIDTH-1:0]  i_dout_pkt,
  output logic                  o_rden_pkt,
  input  logic                  i_empty_meta,
  input  logic [META_WIDTH-1:0] i_dout_meta,
  output logic                  o_rden_meta,
  output logic                  o_data_valid,
  output logic [PKT_WIDTH-1:0]  o_data,
  output logic                  o_meta_valid,
  output logic [META_WIDTH-1:0] o_meta,
  input  logic                  i_ready
`ifdef HYPIPE_OUT_STAT_EN
  ,
  output logic [CNT_WIDTH-1:0]  o_cnt_pkt,
  output logic [CNT_WIDTH-1:0]  o_cnt_drop_beat,
  output logic [CNT_WIDTH-1:0]  o_cnt_err
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t          r_state;
  logic [TW-1:0]   r_toutCnt;

  state_t          w_nextState;
  logic [1:0]      w_tag;
  logic            w_head;
  logic            w_ld;
  logic            w_popPkt;
  logic            w_popMeta;
  logic            w_load;
  logic            w_loadMeta;
  logic            w_err;
  logic            w_dropPop;
  logic            w_toutHit;

  assign w_tag  = i_dout_pkt[PKT_WIDTH-1:PKT_WIDTH-2];
  assign w_head = isHeadTag(w_tag);

  always_comb begin
    w_nextState = r_state;
    w_popPkt    = 1'b0;
    w_popMeta   = 1'b0;
    w_load      = 1'b0;
    w_loadMeta  = 1'b0;
    w_err       = 1'b0;
    w_dropPop   = 1'b0;
    w_toutHit   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!i_empty_pkt) begin
          if (!w_head) begin
            w_nextState = ST_DROP;
          end else if (!i_empty_meta && w_ld) begin
            w_popPkt    = 1'b1;
            w_popMeta   = 1'b1;
            w_load      = 1'b1;
            w_loadMeta  = 1'b1;
            w_nextState = (w_tag == TAG_SINGLE) ? ST_IDLE : ST_BODY;
          end
        end
      end
      ST_BODY: begin
        if (!i_empty_pkt) begin
          // A head arriving mid-packet ends the current one; the head is kept for IDLE.
          if (w_head) begin
            w_err       = 1'b1;
            w_nextState = ST_IDLE;
          end else if (w_ld) begin
            w_popPkt = 1'b1;
            w_load   = 1'b1;
            if (w_tag == TAG_TAIL) begin
              w_nextState = ST_IDLE;
            end
          end
        end else if (r_toutCnt == TW'(TIMEOUT_CYC - 1)) begin
          w_err       = 1'b1;
          w_toutHit   = 1'b1;
          w_nextState = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (!i_empty_pkt) begin
          if (w_head) begin
            w_nextState = ST_IDLE;
          end else begin
            w_popPkt  = 1'b1;
            w_dropPop = 1'b1;
            if (w_tag == TAG_TAIL) begin
              w_nextState = ST_IDLE;
            end
          end
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  assign o_rden_pkt  = w_popPkt && !i_rst;
  assign o_rden_meta = w_popMeta && !i_rst;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Counts consecutive empty-FIFO cycles spent waiting inside a packet.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_toutCnt <= '0;
    end else if (r_state != ST_BODY || w_popPkt || w_toutHit) begin
      r_toutCnt <= '0;
    end else if (i_empty_pkt) begin
      r_toutCnt <= r_toutCnt + 1'b1;
    end
  end

  hypipe_out_reg #(
    .META_WIDTH (META_WIDTH)
  ) u_outReg (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_load       (w_load),
    .i_data       (i_dout_pkt),
    .i_meta_valid (w_loadMeta),
    .i_meta       (i_dout_meta),
    .i_ready      (i_ready),
    .o_ld         (w_ld),
    .o_data_valid (o_data_valid),
    .o_data       (o_data),
    .o_meta_valid (o_meta_valid),
    .o_meta       (o_meta)
  );

`ifdef HYPIPE_OUT_STAT_EN
  logic [CNT_WIDTH-1:0] r_cntPkt;
  logic [CNT_WIDTH-1:0] r_cntDrop;
  logic [CNT_WIDTH-1:0] r_cntErr;

  assign o_cnt_pkt       = r_cntPkt;
  assign o_cnt_drop_beat = r_cntDrop;
  assign o_cnt_err       = r_cntErr;

  // Saturating statistics; they stop at all-ones rather than wrapping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cntPkt  <= '0;
      r_cntDrop <= '0;
      r_cntErr  <= '0;
    end else begin
      if (w_popMeta && r_cntPkt != '1) begin
        r_cntPkt <= r_cntPkt + 1'b1;
      end
      if (w_dropPop && r_cntDrop != '1) begin
        r_cntDrop <= r_cntDrop + 1'b1;
      end
      if (w_err && r_cntErr != '1) begin
        r_cntErr <= r_cntErr + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hypipe_out_sched.sv
// Directed self-checking bench for hypipe_out_sched; the FIFOs are modelled
// as show-ahead queues popped on the DUT's read enables.
module tb_hypipe_out_sched;
  import hypipe_out_sched_pkg::*;

  localparam int MW = 128;
  localparam int CW = 32;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_empty_pkt;
  logic [133:0]    i_dout_pkt;
  logic            o_rden_pkt;
  logic            i_empty_meta;
  logic [MW-1:0]   i_dout_meta;
  logic            o_rden_meta;
  logic            o_data_valid;
  logic [133:0]    o_data;
  logic            o_meta_valid;
  logic [MW-1:0]   o_meta;
  logic            i_ready;
`ifdef HYPIPE_OUT_STAT_EN
  logic [CW-1:0]   o_cnt_pkt;
  logic [CW-1:0]   o_cnt_drop_beat;
  logic [CW-1:0]   o_cnt_err;
`endif

  logic [133:0]    pktQ[$];
  logic [MW-1:0]   metaQ[$];
  logic            recPkt  = 1'b0;
  logic            recMeta = 1'b0;
  int              nCompared = 0;
  int              nMismatch = 0;

  hypipe_out_sched #(
    .META_WIDTH  (MW),
    .TIMEOUT_CYC (16),
    .CNT_WIDTH   (CW)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_empty_pkt     (i_empty_pkt),
    .i_dout_pkt      (i_dout_pkt),
    .o_rden_pkt      (o_rden_pkt),
    .i_empty_meta    (i_empty_meta),
    .i_dout_meta     (i_dout_meta),
    .o_rden_meta     (o_rden_meta),
    .o_data_valid    (o_data_valid),
    .o_data          (o_data),
    .o_meta_valid    (o_meta_valid),
    .o_meta          (o_meta),
    .i_ready         (i_ready)
`ifdef HYPIPE_OUT_STAT_EN
    ,
    .o_cnt_pkt       (o_cnt_pkt),
    .o_cnt_drop_beat (o_cnt_drop_beat),
    .o_cnt_err       (o_cnt_err)
`endif
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [133:0] mkBeat(input logic [1:0] t, input logic [15:0] p);
    return {t, 116'd0, p};
  endfunction

  // Present the queue fronts to the DUT as show-ahead FIFO outputs.
  task automatic applyStimulus();
    i_empty_pkt  = (pktQ.size() == 0);
    i_dout_pkt   = (pktQ.size() > 0) ? pktQ[0] : '0;
    i_empty_meta = (metaQ.size() == 0);
    i_dout_meta  = (metaQ.size() > 0) ? metaQ[0] : '0;
  endtask

  task automatic settle();
    applyStimulus();
    #1;
    recPkt  = o_rden_pkt;
    recMeta = o_rden_meta;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    if (recPkt && pktQ.size() > 0) void'(pktQ.pop_front());
    if (recMeta && metaQ.size() > 0) void'(metaQ.pop_front());
    settle();
  endtask

  task automatic checkOutput(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatch++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkBeat(input string tag, input logic [133:0] expData,
                           input logic expMetaValid, input logic [MW-1:0] expMeta);
    checkOutput({tag, " valid"}, 134'(o_data_valid), 134'(1'b1));
    checkOutput({tag, " data"}, o_data, expData);
    checkOutput({tag, " metaValid"}, 134'(o_meta_valid), 134'(expMetaValid));
    checkOutput({tag, " meta"}, 134'(o_meta), 134'(expMeta));
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " valid"}, 134'(o_data_valid), 134'(1'b0));
    checkOutput({tag, " metaValid"}, 134'(o_meta_valid), 134'(1'b0));
  endtask

  task automatic checkPops(input string tag, input logic expPkt, input logic expMeta);
    checkOutput({tag, " rdenPkt"}, 134'(recPkt), 134'(expPkt));
    checkOutput({tag, " rdenMeta"}, 134'(recMeta), 134'(expMeta));
  endtask

  initial begin
    i_rst   = 1'b1;
    i_ready = 1'b1;

    // Reset with a packet already waiting: nothing may be popped.
    pktQ.push_back(mkBeat(TAG_HEAD, 16'h0001));
    pktQ.push_back(mkBeat(TAG_BODY, 16'h0002));
    pktQ.push_back(mkBeat(TAG_TAIL, 16'h0003));
    metaQ.push_back(MW'(8'hA5));
    settle();
    tick();
    tick();
    checkIdle("rst");
    checkOutput("rst data", o_data, '0);
    checkOutput("rst meta", 134'(o_meta), '0);
    checkPops("rst", 1'b0, 1'b0);

    // Three-beat packet at full throughput.
    i_rst = 1'b0;
    settle();
    checkPops("t1 head", 1'b1, 1'b1);
    tick();
    checkBeat("t1 b0", mkBeat(TAG_HEAD, 16'h0001), 1'b1, MW'(8'hA5));
    checkPops("t1 b0", 1'b1, 1'b0);
    tick();
    checkBeat("t1 b1", mkBeat(TAG_BODY, 16'h0002), 1'b0, MW'(8'hA5));
    checkPops("t1 b1", 1'b1, 1'b0);
    tick();
    checkBeat("t1 b2", mkBeat(TAG_TAIL, 16'h0003), 1'b0, MW'(8'hA5));
    checkPops("t1 b2", 1'b0, 1'b0);
    tick();
    checkIdle("t1 end");

    // Back-to-back single-beat packets.
    pktQ.push_back(mkBeat(TAG_SINGLE, 16'h0011));
    pktQ.push_back(mkBeat(TAG_SINGLE, 16'h0022));
    metaQ.push_back(MW'(8'h01));
    metaQ.push_back(MW'(8'h02));
    settle();
    checkPops("t2 s0", 1'b1, 1'b1);
    tick();
    checkBeat("t2 s0", mkBeat(TAG_SINGLE, 16'h0011), 1'b1, MW'(8'h01));
    checkPops("t2 s1", 1'b1, 1'b1);
    tick();
    checkBeat("t2 s1", mkBeat(TAG_SINGLE, 16'h0022), 1'b1, MW'(8'h02));
    checkPops("t2 end", 1'b0, 1'b0);
    tick();
    checkIdle("t2 end");

    // Head waiting on an empty meta FIFO for five cycles.
    pktQ.push_back(mkBeat(TAG_SINGLE, 16'h0033));
    settle();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      checkPops("t3 wait", 1'b0, 1'b0);
      checkIdle("t3 wait");
    end
    tick();
    metaQ.push_back(MW'(8'h03));
    settle();
    checkPops("t3 meta", 1'b1, 1'b1);
    tick();
    checkBeat("t3 out", mkBeat(TAG_SINGLE, 16'h0033), 1'b1, MW'(8'h03));
    tick();
    checkIdle("t3 end");

    // Downstream stall for three cycles right after the head.
    pktQ.push_back(mkBeat(TAG_HEAD, 16'h0041));
    pktQ.push_back(mkBeat(TAG_BODY, 16'h0042));
    pktQ.push_back(mkBeat(TAG_BODY, 16'h0043));
    pktQ.push_back(mkBeat(TAG_TAIL, 16'h0044));
    metaQ.push_back(MW'(8'h04));
    settle();
    checkPops("t4 head", 1'b1, 1'b1);
    tick();
    checkBeat("t4 h", mkBeat(TAG_HEAD, 16'h0041), 1'b1, MW'(8'h04));
    i_ready = 1'b0;
    settle();
    checkPops("t4 stall0", 1'b0, 1'b0);
    tick();
    checkBeat("t4 stall1", mkBeat(TAG_HEAD, 16'h0041), 1'b1, MW'(8'h04));
    checkPops("t4 stall1", 1'b0, 1'b0);
    tick();
    checkBeat("t4 stall2", mkBeat(TAG_HEAD, 16'h0041), 1'b1, MW'(8'h04));
    checkPops("t4 stall2", 1'b0, 1'b0);
    tick();
    i_ready = 1'b1;
    settle();
    checkBeat("t4 resume", mkBeat(TAG_HEAD, 16'h0041), 1'b1, MW'(8'h04));
    checkPops("t4 resume", 1'b1, 1'b0);
    tick();
    checkBeat("t4 b1", mkBeat(TAG_BODY, 16'h0042), 1'b0, MW'(8'h04));
    checkPops("t4 b1", 1'b1, 1'b0);
    tick();
    checkBeat("t4 b2", mkBeat(TAG_BODY, 16'h0043), 1'b0, MW'(8'h04));
    checkPops("t4 b2", 1'b1, 1'b0);
    tick();
    checkBeat("t4 b3", mkBeat(TAG_TAIL, 16'h0044), 1'b0, MW'(8'h04));
    checkPops("t4 b3", 1'b0, 1'b0);
    tick();
    checkIdle("t4 end");

    // Orphan body/tail beats are dropped before the next packet.
    pktQ.push_back(mkBeat(TAG_BODY, 16'h0051));
    pktQ.push_back(mkBeat(TAG_TAIL, 16'h0052));
    pktQ.push_back(mkBeat(TAG_HEAD, 16'h0053));
    pktQ.push_back(mkBeat(TAG_TAIL, 16'h0054));
    metaQ.push_back(MW'(8'h05));
    settle();
    checkPops("t5 enter", 1'b0, 1'b0);
    tick();
    checkPops("t5 drop0", 1'b1, 1'b0);
    checkIdle("t5 drop0");
    tick();
    checkPops("t5 drop1", 1'b1, 1'b0);
    checkIdle("t5 drop1");
    tick();
    checkPops("t5 head", 1'b1, 1'b1);
    checkIdle("t5 head");
    tick();
    checkBeat("t5 h", mkBeat(TAG_HEAD, 16'h0053), 1'b1, MW'(8'h05));
    checkPops("t5 h", 1'b1, 1'b0);
    tick();
    checkBeat("t5 t", mkBeat(TAG_TAIL, 16'h0054), 1'b0, MW'(8'h05));
    checkPops("t5 t", 1'b0, 1'b0);
    tick();
    checkIdle("t5 end");
`ifdef HYPIPE_OUT_STAT_EN
    checkOutput("t5 cntDrop", 134'(o_cnt_drop_beat), 134'(2));
`endif

    // Packet body never arrives: timeout after 16 empty cycles.
    pktQ.push_back(mkBeat(TAG_HEAD, 16'h0061));
    metaQ.push_back(MW'(8'h06));
    settle();
    checkPops("t6 head", 1'b1, 1'b1);
    tick();
    checkBeat("t6 h", mkBeat(TAG_HEAD, 16'h0061), 1'b1, MW'(8'h06));
    checkPops("t6 h", 1'b0, 1'b0);
    tick();
    checkIdle("t6 starve");
    repeat (14) tick();
`ifdef HYPIPE_OUT_STAT_EN
    checkOutput("t6 cntErr before", 134'(o_cnt_err), 134'(0));
`endif
    tick();
`ifdef HYPIPE_OUT_STAT_EN
    checkOutput("t6 cntErr after", 134'(o_cnt_err), 134'(1));
`endif
    pktQ.push_back(mkBeat(TAG_HEAD, 16'h0071));
    pktQ.push_back(mkBeat(TAG_TAIL, 16'h0072));
    metaQ.push_back(MW'(8'h07));
    settle();
    checkPops("t6 next", 1'b1, 1'b1);
    tick();
    checkBeat("t6 nh", mkBeat(TAG_HEAD, 16'h0071), 1'b1, MW'(8'h07));
    checkPops("t6 nh", 1'b1, 1'b0);
    tick();
    checkBeat("t6 nt", mkBeat(TAG_TAIL, 16'h0072), 1'b0, MW'(8'h07));
    tick();
    checkIdle("t6 end");
`ifdef HYPIPE_OUT_STAT_EN
    checkOutput("end cntPkt", 134'(o_cnt_pkt), 134'(8));
    checkOutput("end cntDrop", 134'(o_cnt_drop_beat), 134'(2));
    checkOutput("end cntErr", 134'(o_cnt_err), 134'(1));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
